u128_to_888_unpack: RTL and testbench
=====================================

# u128_to_888_unpack

Unpacks a 128-bit AXI-Stream video word, made of four 32-bit lanes, into a stream of one RGB888 pixel per clock. Each lane has the layout {8'h00, R, G, B}, and lane 0 is the lowest 32 bits. The block sits on the read side of the frame-buffer / UDP-payload path, downstream of the 128-bit DMA/FIFO and upstream of per-pixel processing. It is the inverse of the RGB888-to-128 packer. It handles partial final words via tkeep, preserves frame/line markers, and flags malformed input.

## Interface
Parameters:
- PARALLEL_NUM, 4, lanes per input word; fixed at 4, other values unsupported.
- PIXEL_WIDTH, 32, bits per lane: 8-bit pad plus RGB888.

Ports:
- i_clk  in  1  sole clock; all logic rising-edge.
- i_rst  in  1  synchronous reset, active-high.
- i_tdata  in  128  packed word; lane j = i_tdata[32j+31:32j].
- i_tkeep  in  16  byte enables; lane j valid iff i_tkeep[4j+3:4j]==4'hF.
- i_tvalid  in  1  input word valid.
- i_tlast  in  1  word carries the last pixel of a line/packet.
- i_tuser  in  1  word carries the first pixel of a frame (SOF).
- o_tready  out  1  input word accepted on edge where i_tvalid & o_tready.
- o_rgb_r  out  8  pixel red, lane bits [23:16].
- o_rgb_g  out  8  pixel green, lane bits [15:8].
- o_rgb_b  out  8  pixel blue, lane bits [7:0].
- o_valid  out  1  pixel valid.
- o_sof  out  1  qualifies o_valid; first pixel of a word accepted with i_tuser=1.
- o_last  out  1  qualifies o_valid; final valid pixel of a word accepted with i_tlast=1.
- i_ready  in  1  downstream accepts pixel on edge where o_valid & i_ready.
- o_keep_err  out  1  sticky; malformed tkeep seen.
- o_alpha_err  out  1  sticky; nonzero pad byte in a valid lane.

## Operation
- Single-word holding buffer: data, lane count n (1..4), lane index idx (0..3), sof, last, full flag.
- Lane count on acceptance: n = length of the contiguous run of fully-kept lanes starting at lane 0.
- o_keep_err is set on acceptance if any of these holds:
  - any keep nibble is neither 4'h0 nor 4'hF;
  - a kept lane follows an unkept lane;
  - n==0.
- With n==0 the word is consumed and dropped: no pixels out, buffer stays empty, its tlast/tuser are discarded.
- o_alpha_err is set on acceptance if bits [32j+31:32j+24] != 0 for any lane j < n. The pixels are still emitted, with the pad byte ignored.
- Output pixel = lane idx of the buffered word.
  - o_valid = full.
  - o_sof = full & sof & (idx==0).
  - o_last = full & last & (idx==n-1).
- Pop (o_valid & i_ready):
  - idx<n-1: idx increments.
  - idx==n-1: buffer empties, or reloads if a new word is accepted on the same edge.
- o_tready = ~i_rst & (~full | (i_ready & idx==n-1)). This is a combinational path from i_ready and gives zero-bubble word-to-word transfer.
- While o_valid=1 and i_ready=0, all pixel outputs hold stable (AXI rule).
- Sticky errors clear only on i_rst.

## Timing
- Reset values (cycle after i_rst high):
  - o_valid, o_sof, o_last, o_keep_err, o_alpha_err = 0;
  - o_rgb_r/g/b = 0;
  - idx = 0, full = 0.
- o_tready = 0 while i_rst=1, and 1 on the first cycle after release.
- Reset mid-word: the buffered pixels are discarded and nothing further is emitted.
- Latency: a word accepted on edge E presents lane 0 on o_valid in the cycle after E.
- Throughput: 1 pixel/clock when i_ready=1 continuously. A 4-lane word occupies 4 cycles, and the next word is accepted on the edge that pops lane 3.
- Error flags assert the cycle after the offending word is accepted.
- Simultaneous pop of the final lane and acceptance of a new word: the new word's lane 0 appears the next cycle with no gap, idx = 0, and sof/last are taken from the new word.

## Test plan
- Reset, then one word 0x00_112233_00_445566_00_778899_00_AABBCC, tkeep=16'hFFFF, tuser=1, tlast=1, i_ready=1 -> pixels 0xAABBCC, 0x778899, 0x445566, 0x112233 on 4 consecutive cycles; o_sof on the first only, o_last on the fourth only.
- 16 back-to-back full words with i_ready held at 1 -> 64 pixels with no gaps; o_tready low exactly 3 of every 4 cycles; pixel order equals lane order.
- Partial word, tkeep=16'h00FF, tlast=1 -> exactly 2 pixels, o_last on the second; no error flags.
- Random i_ready (50%) over 100 words -> output sequence matches the reference unpack; outputs stable while stalled; no pixel lost or duplicated.
- Two malformed words:
  - tkeep=16'h0F0F -> 1 pixel out, o_keep_err=1;
  - tkeep=16'h0000 -> 0 pixels out, word consumed, o_keep_err=1.
- Word with lane 2 pad byte 0x7F, then i_rst pulsed after 1 pixel -> o_alpha_err=1 before the reset; after the reset o_valid=0, both flags=0, and remaining lanes are never emitted.

Source files
------------

// File: rtl/u128_to_888_unpack.sv
// Unpacks a 128-bit AXI-Stream word of four {pad, R, G, B} lanes into one RGB888 pixel per clock.
// Handles partial words via tkeep, preserves SOF/EOL markers and raises sticky error flags.
module u128_to_888_unpack #(
  parameter int PARALLEL_NUM = 4,
  parameter int PIXEL_WIDTH  = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [PARALLEL_NUM*PIXEL_WIDTH-1:0]   i_tdata,
  input  logic [PARALLEL_NUM*PIXEL_WIDTH/8-1:0] i_tkeep,
  input  logic                                  i_tvalid,
  input  logic                                  i_tlast,
  input  logic                                  i_tuser,
  output logic                                  o_tready,
  output logic [7:0]                            o_rgb_r,
  output logic [7:0]                            o_rgb_g,
  output logic [7:0]                            o_rgb_b,
  output logic                                  o_valid,
  output logic                                  o_sof,
  output logic                                  o_last,
  input  logic                                  i_ready,
  output logic                                  o_keep_err,
  output logic                                  o_alpha_err
);

  localparam int DATA_W = PARALLEL_NUM * PIXEL_WIDTH;
  localparam int LANE_B = PIXEL_WIDTH / 8;
  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(PARALLEL_NUM + 1);
  localparam int IDX_W  = $clog2(PARALLEL_NUM);

  // Length of the run of fully-kept lanes starting at lane 0.
  function automatic logic [CNT_W-1:0] lane_count(input logic [KEEP_W-1:0] keep);
    logic [CNT_W-1:0] cnt;
    logic             run;
    cnt = '0;
    run = 1'b1;
    for (int j = 0; j < PARALLEL_NUM; j++) begin
      if (run && keep[j*LANE_B +: LANE_B] == {LANE_B{1'b1}}) cnt = cnt + CNT_W'(1);
      else run = 1'b0;
    end
    return cnt;
  endfunction

  function automatic logic keep_malformed(input logic [KEEP_W-1:0] keep);
    logic             bad;
    logic             gap;
    logic [LANE_B-1:0] nib;
    bad = 1'b0;
    gap = 1'b0;
    for (int j = 0; j < PARALLEL_NUM; j++) begin
      nib = keep[j*LANE_B +: LANE_B];
      if (nib != '0 && nib != '1) bad = 1'b1;
      if (nib == '1 && gap)       bad = 1'b1;
      if (nib != '1)              gap = 1'b1;
    end
    return bad | (lane_count(keep) == '0);
  endfunction

  // Only lanes that will actually be emitted are inspected for a nonzero pad byte.
  function automatic logic pad_nonzero(input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] cnt);
    logic bad;
    bad = 1'b0;
    for (int j = 0; j < PARALLEL_NUM; j++) begin
      if (CNT_W'(j) < cnt && data[j*PIXEL_WIDTH + PIXEL_WIDTH - 8 +: 8] != 8'h00) bad = 1'b1;
    end
    return bad;
  endfunction

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              full_q, full_d;
  logic              sof_q, sof_d;
  logic              last_q, last_d;
  logic              keep_err_q, keep_err_d;
  logic              alpha_err_q, alpha_err_d;

  logic [CNT_W-1:0]  n_in;
  logic              last_lane;
  logic              pop;
  logic              accept;
  logic              load;
  logic [23:0]       pix;

  assign n_in      = lane_count(i_tkeep);
  assign last_lane = ({1'b0, idx_q} == (n_q - CNT_W'(1)));
  assign pop       = full_q & i_ready;
  assign o_tready  = ~i_rst & (~full_q | (i_ready & last_lane));
  assign accept    = i_tvalid & o_tready;
  assign load      = accept & (n_in != '0);

  always_comb begin
    full_d      = full_q;
    idx_d       = idx_q;
    n_d         = n_q;
    sof_d       = sof_q;
    last_d      = last_q;
    keep_err_d  = keep_err_q  | (accept & keep_malformed(i_tkeep));
    alpha_err_d = alpha_err_q | (accept & pad_nonzero(i_tdata, n_in));
    if (load) begin
      // A new word may land on the same edge that pops the previous word's final lane.
      full_d = 1'b1;
      idx_d  = '0;
      n_d    = n_in;
      sof_d  = i_tuser;
      last_d = i_tlast;
    end else if (pop) begin
      if (last_lane) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q      <= 1'b0;
      idx_q       <= '0;
      n_q         <= '0;
      sof_q       <= 1'b0;
      last_q      <= 1'b0;
      keep_err_q  <= 1'b0;
      alpha_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      sof_q       <= sof_d;
      last_q      <= last_d;
      keep_err_q  <= keep_err_d;
      alpha_err_q <= alpha_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (load) data_q <= i_tdata;
  end

  // Pixel outputs are gated by full so the unreset data buffer never leaks out.
  assign pix         = data_q[idx_q*PIXEL_WIDTH +: 24];
  assign o_rgb_r     = full_q ? pix[23:16] : 8'h00;
  assign o_rgb_g     = full_q ? pix[15:8]  : 8'h00;
  assign o_rgb_b     = full_q ? pix[7:0]   : 8'h00;
  assign o_valid     = full_q;
  assign o_sof       = full_q & sof_q & (idx_q == '0);
  assign o_last      = full_q & last_q & last_lane;
  assign o_keep_err  = keep_err_q;
  assign o_alpha_err = alpha_err_q;

endmodule

// File: tb/tb_u128_to_888_unpack.sv
// Directed and table-driven bench for u128_to_888_unpack with a pixel scoreboard.
module tb_u128_to_888_unpack;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [127:0] i_tdata = '0;
  logic [15:0]  i_tkeep = '0;
  logic         i_tvalid = 1'b0;
  logic         i_tlast = 1'b0;
  logic         i_tuser = 1'b0;
  logic         o_tready;
  logic [7:0]   o_rgb_r, o_rgb_g, o_rgb_b;
  logic         o_valid, o_sof, o_last;
  logic         i_ready = 1'b1;
  logic         o_keep_err, o_alpha_err;

  always #5 i_clk = ~i_clk;

  u128_to_888_unpack dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tdata(i_tdata), .i_tkeep(i_tkeep),
    .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tuser(i_tuser), .o_tready(o_tready),
    .o_rgb_r(o_rgb_r), .o_rgb_g(o_rgb_g), .o_rgb_b(o_rgb_b), .o_valid(o_valid),
    .o_sof(o_sof), .o_last(o_last), .i_ready(i_ready),
    .o_keep_err(o_keep_err), .o_alpha_err(o_alpha_err)
  );

  typedef struct {
    int          cyc;
    logic [23:0] pix;
    logic        sof;
    logic        last;
  } pix_t;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         user;
    logic         last;
    int           npix;
    logic         kerr;
    logic         aerr;
  } vec_t;

  pix_t        got[$];
  pix_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        acc = 1'b0;
  logic        last_tready = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        stall_q = 1'b0;
  logic [25:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    pix_t p;
    @(negedge i_clk);
    cyc++;
    if (!i_rst && stall_q) begin
      check("stall_valid", 32'(o_valid), 32'd1);
      check("stall_hold", 32'({o_sof, o_last, o_rgb_r, o_rgb_g, o_rgb_b}), 32'(held));
    end
    stall_q = !i_rst && o_valid && !i_ready;
    held    = {o_sof, o_last, o_rgb_r, o_rgb_g, o_rgb_b};
    if (!i_rst && o_valid && i_ready) begin
      p.cyc  = cyc;
      p.pix  = {o_rgb_r, o_rgb_g, o_rgb_b};
      p.sof  = o_sof;
      p.last = o_last;
      got.push_back(p);
    end
    last_tready = o_tready;
    acc = i_tvalid && o_tready;
    @(posedge i_clk);
    #1;
    if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic u, input logic l,
                      input int nexp, output int lows);
    int   w;
    pix_t p;
    w = 0;
    lows = 0;
    i_tdata = d; i_tkeep = k; i_tuser = u; i_tlast = l; i_tvalid = 1'b1;
    do begin
      tick();
      if (!last_tready) lows++;
      w++;
    end while (!acc && w < 200);
    check("word_accepted", 32'(acc), 32'd1);
    for (int j = 0; j < nexp; j++) begin
      p.cyc  = 0;
      p.pix  = d[32*j +: 24];
      p.sof  = u && (j == 0);
      p.last = l && (j == nexp - 1);
      exp_q.push_back(p);
    end
    i_tvalid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (got.size() < exp_q.size() && k < 1000) begin
      tick();
      k++;
    end
    repeat (4) tick();
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check({tag, "_pix"},  32'(got[i].pix),  32'(exp_q[i].pix));
      check({tag, "_sof"},  32'(got[i].sof),  32'(exp_q[i].sof));
      check({tag, "_last"}, 32'(got[i].last), 32'(exp_q[i].last));
    end
  endtask

  task automatic check_gapless(input string tag);
    for (int i = 1; i < got.size(); i++)
      check({tag, "_gap"}, 32'(got[i].cyc - got[0].cyc), 32'(i));
  endtask

  task automatic clear_q();
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    check("tready_in_reset", 32'(last_tready), 32'd0);
    tick();
    i_rst = 1'b0;
    stall_q = 1'b0;
    clear_q();
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_sof_last"}, 32'({o_sof, o_last}), 32'd0);
    check({tag, "_rgb"}, 32'({o_rgb_r, o_rgb_g, o_rgb_b}), 32'd0);
    check({tag, "_errs"}, 32'({o_keep_err, o_alpha_err}), 32'd0);
    check({tag, "_tready"}, 32'(o_tready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs[10];
    int           lows;
    int           total_low;
    logic [127:0] d;

    vecs[0] = '{128'h00010203_00040506_00070809_000A0B0C, 16'h0FFF, 1'b1, 1'b1, 3, 1'b0, 1'b0};
    vecs[1] = '{128'h00112233_00445566_00778899_00AABBCC, 16'h00FF, 1'b0, 1'b1, 2, 1'b0, 1'b0};
    vecs[2] = '{128'h00112233_00445566_00778899_00AABBCC, 16'h0F0F, 1'b1, 1'b1, 1, 1'b1, 1'b0};
    vecs[3] = '{128'h00112233_00445566_00778899_00AABBCC, 16'h0000, 1'b1, 1'b1, 0, 1'b1, 1'b0};
    vecs[4] = '{128'h00112233_00445566_00778899_00AABBCC, 16'hFFF0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[5] = '{128'h00112233_00445566_00778899_00AABBCC, 16'h007F, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[6] = '{128'h55112233_66445566_00778899_00AABBCC, 16'h00FF, 1'b0, 1'b1, 2, 1'b0, 1'b0};
    vecs[7] = '{128'h00112233_00445566_00778899_80AABBCC, 16'hFFFF, 1'b1, 1'b0, 4, 1'b0, 1'b1};
    vecs[8] = '{128'h00112233_00445566_00778899_00A1B2C3, 16'h000F, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    vecs[9] = '{128'h00112233_00445566_00778899_00AABBCC, 16'hF0FF, 1'b0, 1'b1, 2, 1'b1, 1'b0};

    do_reset();
    check_idle("reset");

    // Single full word from the test plan.
    send(128'h00112233_00445566_00778899_00AABBCC, 16'hFFFF, 1'b1, 1'b1, 4, lows);
    drain();
    compare("basic");
    check_gapless("basic");
    if (got.size() == 4) begin
      check("basic_p0", 32'(got[0].pix), 32'h00AABBCC);
      check("basic_p3", 32'(got[3].pix), 32'h00112233);
      check("basic_marks", 32'({got[0].sof, got[1].sof, got[3].last, got[2].last}), 32'b1010);
    end
    clear_q();

    // 16 back-to-back words with downstream always ready.
    total_low = 0;
    for (int w = 0; w < 16; w++) begin
      d = {8'h00, 24'(24'h300000 + w), 8'h00, 24'(24'h200000 + w),
           8'h00, 24'(24'h100000 + w), 8'h00, 24'(w)};
      send(d, 16'hFFFF, w == 0, 1'b1, 4, lows);
      total_low += lows;
    end
    drain();
    compare("b2b");
    check_gapless("b2b");
    check("b2b_tready_low", 32'(total_low), 32'd45);
    clear_q();

    for (int i = 0; i < 10; i++) begin
      do_reset();
      send(vecs[i].data, vecs[i].keep, vecs[i].user, vecs[i].last, vecs[i].npix, lows);
      drain();
      compare($sformatf("vec%0d", i));
      check($sformatf("vec%0d_keep_err", i), 32'(o_keep_err), 32'(vecs[i].kerr));
      check($sformatf("vec%0d_alpha_err", i), 32'(o_alpha_err), 32'(vecs[i].aerr));
    end

    // Keep error stays set across a following clean word.
    do_reset();
    send(128'h00112233_00445566_00778899_00AABBCC, 16'h0F0F, 1'b0, 1'b0, 1, lows);
    send(128'h00010203_00040506_00070809_000A0B0C, 16'hFFFF, 1'b1, 1'b1, 4, lows);
    drain();
    compare("sticky");
    check("sticky_keep_err", 32'(o_keep_err), 32'd1);

    // Random downstream stalls over 100 words.
    do_reset();
    rnd_ready = 1'b1;
    for (int w = 0; w < 100; w++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(d, 16'hFFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4, lows);
    end
    drain();
    compare("random");
    rnd_ready = 1'b0;
    i_ready = 1'b1;
    repeat (2) tick();

    // Alpha error on lane 2, then reset after the first pixel.
    do_reset();
    send(128'h00010203_7F040506_00070809_000A0B0C, 16'hFFFF, 1'b1, 1'b1, 4, lows);
    tick();
    #1;
    check("alpha_before_reset", 32'(o_alpha_err), 32'd1);
    check("alpha_one_pixel", 32'(got.size()), 32'd1);
    if (got.size() >= 1) check("alpha_p0", 32'(got[0].pix), 32'h000A0B0C);
    i_rst = 1'b1;
    tick();
    check("tready_mid_reset", 32'(last_tready), 32'd0);
    i_rst = 1'b0;
    #1;
    check("post_reset_valid", 32'(o_valid), 32'd0);
    check("post_reset_errs", 32'({o_keep_err, o_alpha_err}), 32'd0);
    repeat (6) tick();
    check("post_reset_no_pixels", 32'(got.size()), 32'd1);
    check("post_reset_idle", 32'(o_valid), 32'd0);
    clear_q();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
